// File: rtl/muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl : HI/LO owner with pipelined multiplier and radix-2 divider.
// Optional macro MULDIV_EARLY_OUT_EN : single-cycle trivial divides.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module muldiv_ctrl #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exe_valid,
  input  logic [7:0]  div_mul,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        md_stall,
  output logic        busy,
  output logic [31:0] hilo_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  localparam logic [4:0] MUL_CNT = 5'(MUL_LAT - 1);

  state_t      state, state_n;
  logic [4:0]  cnt, cnt_n;
  logic [31:0] hi_n, lo_n;
  logic [32:0] mul_a, mul_a_n, mul_b, mul_b_n;
  logic [31:0] rem, rem_n, quo, quo_n, dvsr, dvsr_n, raw_a, raw_a_n;
  logic        neg_q, neg_q_n, neg_r, neg_r_n, dbz, dbz_n;

  logic        has_op, issue;
  logic        op_div, op_divu, op_mult, op_multu, op_mflo, op_mthi, op_mtlo;
  logic [31:0] a_mag, b_mag;
  logic [63:0] prod;
  logic [32:0] shifted, diff;

  // Priority decode: div > divu > mult > multu > mfhi > mflo > mthi > mtlo
  assign op_div   = div_mul[7];
  assign op_divu  = ~div_mul[7]       & div_mul[6];
  assign op_mult  = ~(|div_mul[7:6])  & div_mul[5];
  assign op_multu = ~(|div_mul[7:5])  & div_mul[4];
  assign op_mflo  = ~(|div_mul[7:3])  & div_mul[2];
  assign op_mthi  = ~(|div_mul[7:2])  & div_mul[1];
  assign op_mtlo  = ~(|div_mul[7:1])  & div_mul[0];

  assign has_op     = |div_mul;
  assign busy       = (state != S_IDLE);
  assign md_stall   = exe_valid & has_op & busy;
  assign issue      = exe_valid & has_op & ~busy & ~flush;
  assign hilo_rdata = op_mflo ? lo : hi;

  assign a_mag = (op_div & src_a[31]) ? (~src_a + 32'd1) : src_a;
  assign b_mag = (op_div & src_b[31]) ? (~src_b + 32'd1) : src_b;

  // 33x33 product reduced mod 2^64 is the exact 64-bit result.
  assign prod = {{31{mul_a[32]}}, mul_a} * {{31{mul_b[32]}}, mul_b};

  // One restoring step: remainder never exceeds the divisor, so bit 32 is the sign.
  assign shifted = {rem, quo[31]};
  assign diff    = shifted - {1'b0, dvsr};

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi;
    lo_n    = lo;
    mul_a_n = mul_a;
    mul_b_n = mul_b;
    rem_n   = rem;
    quo_n   = quo;
    dvsr_n  = dvsr;
    raw_a_n = raw_a;
    neg_q_n = neg_q;
    neg_r_n = neg_r;
    dbz_n   = dbz;
    case (state)
      S_IDLE: begin
        if (issue) begin
          if (op_div | op_divu) begin
            rem_n   = 32'd0;
            quo_n   = a_mag;
            dvsr_n  = b_mag;
            raw_a_n = src_a;
            neg_q_n = op_div & (src_a[31] ^ src_b[31]);
            neg_r_n = op_div & src_a[31];
            dbz_n   = (src_b == 32'd0);
            cnt_n   = 5'd31;
            state_n = S_DIV;
`ifdef MULDIV_EARLY_OUT_EN
            if ((src_b == 32'd0) || (a_mag < b_mag)) begin
              rem_n   = a_mag;
              quo_n   = 32'd0;
              state_n = S_FIX;
            end
`endif
          end else if (op_mult | op_multu) begin
            mul_a_n = {op_mult & src_a[31], src_a};
            mul_b_n = {op_mult & src_b[31], src_b};
            cnt_n   = MUL_CNT;
            state_n = S_MUL;
          end else if (op_mthi) begin
            hi_n = src_a;
          end else if (op_mtlo) begin
            lo_n = src_a;
          end
        end
      end
      S_MUL: begin
        if (flush) begin
          state_n = S_IDLE;
        end else if (cnt == 5'd0) begin
          hi_n    = prod[63:32];
          lo_n    = prod[31:0];
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt - 5'd1;
        end
      end
      S_DIV: begin
        if (flush) begin
          state_n = S_IDLE;
        end else begin
          rem_n = diff[32] ? shifted[31:0] : diff[31:0];
          quo_n = {quo[30:0], ~diff[32]};
          if (cnt == 5'd0) state_n = S_FIX;
          else             cnt_n   = cnt - 5'd1;
        end
      end
      S_FIX: begin
        if (!flush) begin
          if (dbz) begin
            lo_n = 32'hFFFF_FFFF;
            hi_n = raw_a;
          end else begin
            lo_n = neg_q ? (~quo + 32'd1) : quo;
            hi_n = neg_r ? (~rem + 32'd1) : rem;
          end
        end
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 5'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      mul_a <= 33'd0;
      mul_b <= 33'd0;
      rem   <= 32'd0;
      quo   <= 32'd0;
      dvsr  <= 32'd0;
      raw_a <= 32'd0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dbz   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi    <= hi_n;
      lo    <= lo_n;
      mul_a <= mul_a_n;
      mul_b <= mul_b_n;
      rem   <= rem_n;
      quo   <= quo_n;
      dvsr  <= dvsr_n;
      raw_a <= raw_a_n;
      neg_q <= neg_q_n;
      neg_r <= neg_r_n;
      dbz   <= dbz_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_muldiv_ctrl : directed + random bench with an arithmetic HI/LO model.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_ctrl;

  localparam int MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        exe_valid = 1'b0;
  logic [7:0]  div_mul = 8'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        flush = 1'b0;
  logic        md_stall, busy;
  logic [31:0] hilo_rdata, hi, lo;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .exe_valid(exe_valid), .div_mul(div_mul),
    .src_a(src_a), .src_b(src_b), .flush(flush), .md_stall(md_stall),
    .busy(busy), .hilo_rdata(hilo_rdata), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Model: architectural HI/LO, cycles of busy remaining, pending result.
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, r_hi = 32'd0, r_lo = 32'd0;
  int          m_rem = 0;
  bit          chk_en = 1'b0;
  int          n_pass = 0, n_tot = 0;
  logic        s_stall, s_busy;
  logic [31:0] s_rdata, s_hi, s_lo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mag(input logic [31:0] v, input bit sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

  task automatic model_issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    if (op[7] || op[6]) begin
      if (b == 32'd0) begin
        r_lo = 32'hFFFF_FFFF;
        r_hi = a;
      end else if (op[7]) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q = sa / sb;
        r = sa % sb;
        r_lo = 32'(q);
        r_hi = 32'(r);
      end else begin
        r_lo = a / b;
        r_hi = a % b;
      end
      m_rem = 33;
`ifdef MULDIV_EARLY_OUT_EN
      if (b == 32'd0 || mag(a, op[7]) < mag(b, op[7])) m_rem = 1;
`endif
    end else if (op[5] || op[4]) begin
      if (op[5]) p = 64'(longint'($signed(a)) * longint'($signed(b)));
      else       p = {32'd0, a} * {32'd0, b};
      r_hi = p[63:32];
      r_lo = p[31:0];
      m_rem = MUL_LAT;
    end else if (op[3] || op[2]) begin
      // reads have no architectural effect
    end else if (op[1]) begin
      m_hi = a;
    end else begin
      m_lo = a;
    end
  endtask

  task automatic step(input logic v, input logic [7:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic fl, input logic rs);
    logic e_busy, e_stall, acc;
    @(negedge clk);
    exe_valid = v; div_mul = op; src_a = a; src_b = b; flush = fl; reset = rs;
    #1;
    s_stall = md_stall; s_busy = busy; s_rdata = hilo_rdata; s_hi = hi; s_lo = lo;
    e_busy  = (m_rem > 0);
    e_stall = v && (op != 8'd0) && e_busy;
    acc     = v && (op != 8'd0) && !e_stall && !fl;
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, e_busy});
      chk("md_stall", {31'd0, md_stall}, {31'd0, e_stall});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      if (acc && op[7:4] == 4'd0 && op[3]) chk("mfhi_rdata", hilo_rdata, m_hi);
      if (acc && op[7:3] == 5'd0 && op[2]) chk("mflo_rdata", hilo_rdata, m_lo);
    end
    @(posedge clk);
    if (rs) begin
      m_hi = 32'd0; m_lo = 32'd0; m_rem = 0;
      chk_en = 1'b1;
    end else if (m_rem > 0) begin
      if (fl) m_rem = 0;
      else begin
        m_rem--;
        if (m_rem == 0) begin
          m_hi = r_hi;
          m_lo = r_lo;
        end
      end
    end else if (acc) begin
      model_issue(op, a, b);
    end
  endtask

  task automatic idle();
    step(1'b0, 8'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // Counts busy cycles following an issue; ends at the first idle sample.
  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 60; k++) begin
      idle();
      if (!s_busy) return;
      n++;
    end
    chk("busy_timeout", 32'd1, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'($urandom_range(0, 20));
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n, stalls;
    bit got;
    logic [7:0] op;
    int r;

    step(1'b0, 8'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 8'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    idle();
    chk("reset_hi", s_hi, 32'd0);
    chk("reset_busy", {31'd0, s_busy}, 32'd0);

    step(1'b1, 8'h20, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    count_busy(n);
    chk("mult_busy_len", n, MUL_LAT);
    chk("mult_hi", s_hi, 32'hFFFF_FFFF);
    chk("mult_lo", s_lo, 32'hFFFF_FFFE);
    step(1'b1, 8'h10, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    count_busy(n);
    chk("multu_hi", s_hi, 32'h0000_0001);
    chk("multu_lo", s_lo, 32'hFFFF_FFFE);

    step(1'b1, 8'h80, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    count_busy(n);
    chk("div_busy_len", n, 33);
    chk("div_lo", s_lo, 32'hFFFF_FFFD);
    chk("div_hi", s_hi, 32'hFFFF_FFFF);

    step(1'b1, 8'h40, 32'd100, 32'd7, 1'b0, 1'b0);
    stalls = 0; got = 0;
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 8'h04, 32'd0, 32'd0, 1'b0, 1'b0);
      if (!s_stall) begin got = 1; break; end
      stalls++;
    end
    chk("divu_stall_len", stalls, 33);
    chk("divu_mflo_seen", {31'd0, got}, 32'd1);
    chk("divu_mflo", s_rdata, 32'd14);
    step(1'b1, 8'h08, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("divu_mfhi", s_rdata, 32'd2);

    step(1'b1, 8'h40, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    count_busy(n);
`ifdef MULDIV_EARLY_OUT_EN
    chk("dbz_busy_len", n, 1);
`else
    chk("dbz_busy_len", n, 33);
`endif
    chk("dbz_lo", s_lo, 32'hFFFF_FFFF);
    chk("dbz_hi", s_hi, 32'h1234_5678);

    step(1'b1, 8'h02, 32'hA5A5_A5A5, 32'd0, 1'b0, 1'b0);
    step(1'b1, 8'h01, 32'h5A5A_5A5A, 32'd0, 1'b0, 1'b0);
    step(1'b1, 8'h80, 32'd1000, 32'd3, 1'b0, 1'b0);
    repeat (9) idle();
    step(1'b0, 8'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    idle();
    chk("flush_busy", {31'd0, s_busy}, 32'd0);
    chk("flush_hi", s_hi, 32'hA5A5_A5A5);
    chk("flush_lo", s_lo, 32'h5A5A_5A5A);

    step(1'b1, 8'h20, 32'd3, 32'd4, 1'b0, 1'b0);
    idle();
    step(1'b0, 8'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    step(1'b1, 8'h08, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("rst_mul_busy", {31'd0, s_busy}, 32'd0);
    chk("rst_mul_stall", {31'd0, s_stall}, 32'd0);
    chk("rst_mul_hi", s_hi, 32'd0);
    chk("rst_mul_lo", s_lo, 32'd0);

    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 5)       op = 8'd0;
      else if (r < 12) op = 8'($urandom_range(1, 255));
      else             op = 8'(1 << $urandom_range(0, 7));
      step(($urandom_range(0, 9) < 8), op, pick(), pick(),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
